// File: rtl/dmem_ctrl.sv
// dmem_ctrl: valid/ready data memory with RISC-V sub-word loads/stores and configurable read latency.
// Define DMEM_STATS_EN to add the stat_loads/stat_stores/stat_errs handshake counters.
module dmem_ctrl #(
    parameter int MEM_DEPTH = 16384,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_errs
`endif
);
    localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state;
    logic [3:0] cnt;
    logic write_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0] funct3_q;
    logic [31:0] mem [MEM_DEPTH];
    logic accept, enter_resp, a_write, a_err, commit;
    logic [31:0] a_addr, a_wdata, word, rd, wd;
    logic [2:0] a_f;
    logic [AW-1:0] idx;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;
    logic [3:0] be;
    // With LATENCY=1 the access happens on the accept edge itself, so decode straight from the request inputs.
    always_comb begin
        accept = req_valid && req_ready && state == IDLE;
        enter_resp = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
        a_write = state == IDLE ? req_write : write_q;
        a_addr = state == IDLE ? req_addr : addr_q;
        a_wdata = state == IDLE ? req_wdata : wdata_q;
        a_f = state == IDLE ? req_funct3 : funct3_q;
        idx = a_addr[AW+1:2];
        word = mem[idx];
        a_err = (a_write ? (a_f[2] || a_f[1:0] == 2'd3) : (a_f[1:0] == 2'd3 || a_f == 3'd6))
             || (a_f[1:0] == 2'd1 && a_addr[0])
             || (a_f[1:0] == 2'd2 && a_addr[1:0] != 2'd0)
             || ({2'b0, a_addr[31:2]} >= 32'(MEM_DEPTH));
        byte_sel = word[{a_addr[1:0], 3'b0} +: 8];
        half_sel = a_addr[1] ? word[31:16] : word[15:0];
        rd = a_f[1:0] == 2'd0 ? {{24{byte_sel[7] & ~a_f[2]}}, byte_sel}
           : a_f[1:0] == 2'd1 ? {{16{half_sel[15] & ~a_f[2]}}, half_sel} : word;
        be = a_f[1:0] == 2'd0 ? 4'b0001 << a_addr[1:0]
           : a_f[1:0] == 2'd1 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd = a_f[1:0] == 2'd0 ? {4{a_wdata[7:0]}} : a_f[1:0] == 2'd1 ? {2{a_wdata[15:0]}} : a_wdata;
        commit = enter_resp && a_write && !a_err;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++) if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            req_ready <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
            cnt <= '0;
            write_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            funct3_q <= '0;
        end else begin
            if (enter_resp) begin
                state <= RESP;
                resp_valid <= 1'b1;
                resp_err <= a_err;
                resp_rdata <= (a_err || a_write) ? '0 : rd;
            end
            case (state)
                IDLE: begin
                    req_ready <= ~accept;
                    if (accept) begin
                        write_q <= req_write;
                        addr_q <= req_addr;
                        wdata_q <= req_wdata;
                        funct3_q <= req_funct3;
                        cnt <= 4'(LATENCY - 1);
                        if (LATENCY > 1) state <= WAIT;
                    end
                end
                WAIT: cnt <= cnt - 4'd1;
                RESP: if (resp_ready) begin
                    state <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_loads <= '0;
            stat_stores <= '0;
            stat_errs <= '0;
        end else if (state == RESP && resp_ready) begin
            stat_errs <= stat_errs + 32'(resp_err);
            stat_loads <= stat_loads + 32'(!resp_err && !write_q);
            stat_stores <= stat_stores + 32'(!resp_err && write_q);
        end
    end
`endif
endmodule
